// File: rtl/fetch_stage_if.sv
// fetch_stage_if
//   Groups the fetch stage's bus signals: instruction-memory req/ack port,
//   branch redirect from execute, and the valid/ready port toward decode.
//   master : the fetch stage side
//   slave  : the environment side (memory, execute, decode)
interface fetch_stage_if;
  logic        imem_req;
  logic [15:0] imem_addr;
  logic        imem_ack;
  logic [15:0] imem_rdata;
  logic        branch_taken;
  logic [15:0] branch_target;
  logic        if_valid;
  logic        if_ready;
  logic [15:0] if_instr;
  logic [15:0] if_pc;
  logic [1:0]  if_op;

  modport master (
    output imem_req, imem_addr,
    input  imem_ack, imem_rdata,
    input  branch_taken, branch_target,
    output if_valid, if_instr, if_pc, if_op,
    input  if_ready
  );

  modport slave (
    input  imem_req, imem_addr,
    output imem_ack, imem_rdata,
    output branch_taken, branch_target,
    input  if_valid, if_instr, if_pc, if_op,
    output if_ready
  );
endinterface

// File: rtl/fetch_stage.sv
// fetch_stage
//   Instruction-fetch stage of the 16-bit core. Owns the PC, keeps at most one
//   instruction-memory request outstanding, buffers returned instructions in a
//   BUF_DEPTH-entry FIFO and presents the head to decode. Branch redirects
//   flush the FIFO and drop the response of any request already in flight.
//
// Parameters
//   RESET_PC  : PC after reset (bit0 must be 0)
//   BUF_DEPTH : FIFO entries, 2 or 4
//
// Ports
//   clk            : clock, rising edge
//   rst            : synchronous active-high reset
//   bus (master)   : imem_req/imem_addr/imem_ack/imem_rdata,
//                    branch_taken/branch_target,
//                    if_valid/if_ready/if_instr/if_pc/if_op
//   perf_fetch_cnt : (IF_PERF_CNT_EN) instructions pushed, saturating
//   perf_flush_cnt : (IF_PERF_CNT_EN) cycles with branch_taken, saturating
//
// Optional feature macro: IF_PERF_CNT_EN
//
// state   | meaning
// --------+------------------------------------------------
// IDLE    | no request outstanding
// WAIT    | request outstanding, response will be kept
// DISCARD | request outstanding, response will be dropped
module fetch_stage #(
  parameter logic [15:0] RESET_PC  = 16'h0000,
  parameter int          BUF_DEPTH = 2
) (
  input  logic          clk,
  input  logic          rst,
  fetch_stage_if.master bus
`ifdef IF_PERF_CNT_EN
  ,
  output logic [15:0]   perf_fetch_cnt,
  output logic [15:0]   perf_flush_cnt
`endif
);

  localparam int PW = $clog2(BUF_DEPTH);
  localparam int CW = $clog2(BUF_DEPTH + 1);
  localparam logic [CW-1:0] DEPTH_C = CW'(BUF_DEPTH);

  typedef enum logic [1:0] {IDLE, WAIT, DISCARD} state_t;

  state_t        state_q, state_d;
  logic [15:0]   pc_q, pc_d;
  logic [15:0]   addr_q, addr_d;
  logic          req_q, req_d;
  logic [15:0]   instr_mem_q [BUF_DEPTH];
  logic [15:0]   instr_mem_d [BUF_DEPTH];
  logic [15:0]   pc_mem_q [BUF_DEPTH];
  logic [15:0]   pc_mem_d [BUF_DEPTH];
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [CW-1:0] count_q, count_d;

  logic          pop;
  logic          push;
  logic          flush;
  logic [CW-1:0] count_after_pop;
  logic [15:0]   target;
  logic [15:0]   pc_inc;
  logic          unused_target_bit0;

  assign target             = {bus.branch_target[15:1], 1'b0};
  assign unused_target_bit0 = bus.branch_target[0];
  assign pc_inc             = pc_q + 16'd2;
  assign flush              = bus.branch_taken;
  assign pop                = bus.if_valid && bus.if_ready;
  assign count_after_pop    = count_q - CW'(pop);

  // Next state, PC and request control
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    addr_d  = addr_q;
    req_d   = req_q;
    push    = 1'b0;
    case (state_q)
      IDLE: begin
        // A redirect here only moves the PC; the request to the target goes
        // out on the following cycle.
        if (bus.branch_taken) begin
          pc_d = target;
        end else if (count_after_pop < DEPTH_C) begin
          req_d   = 1'b1;
          addr_d  = pc_q;
          state_d = WAIT;
        end
      end
      WAIT: begin
        if (bus.branch_taken) begin
          pc_d = target;
          if (bus.imem_ack) begin
            req_d   = 1'b0;
            state_d = IDLE;
          end else begin
            state_d = DISCARD;
          end
        end else if (bus.imem_ack) begin
          push = 1'b1;
          pc_d = pc_inc;
          // Room left after this push: keep req high for a back-to-back fetch
          if ((count_after_pop + CW'(1)) < DEPTH_C) begin
            addr_d = pc_inc;
          end else begin
            req_d   = 1'b0;
            state_d = IDLE;
          end
        end
      end
      DISCARD: begin
        if (bus.branch_taken) begin
          pc_d = target;
        end
        if (bus.imem_ack) begin
          req_d   = 1'b0;
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
        req_d   = 1'b0;
      end
    endcase
  end

  // Instruction FIFO; a flush wins over any push/pop in the same cycle
  always_comb begin
    instr_mem_d = instr_mem_q;
    pc_mem_d    = pc_mem_q;
    rd_ptr_d    = rd_ptr_q;
    wr_ptr_d    = wr_ptr_q;
    count_d     = count_q + CW'(push) - CW'(pop);
    if (push) begin
      instr_mem_d[wr_ptr_q] = bus.imem_rdata;
      pc_mem_d[wr_ptr_q]    = addr_q;
      wr_ptr_d              = wr_ptr_q + PW'(1);
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + PW'(1);
    end
    if (flush) begin
      rd_ptr_d = '0;
      wr_ptr_d = '0;
      count_d  = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      pc_q     <= RESET_PC;
      addr_q   <= RESET_PC;
      req_q    <= 1'b0;
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      state_q  <= state_d;
      pc_q     <= pc_d;
      addr_q   <= addr_d;
      req_q    <= req_d;
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage needs no reset; entries are only visible once counted in
  always_ff @(posedge clk) begin
    instr_mem_q <= instr_mem_d;
    pc_mem_q    <= pc_mem_d;
  end

  assign bus.imem_req  = req_q;
  assign bus.imem_addr = addr_q;
  assign bus.if_valid  = (count_q != '0);
  assign bus.if_instr  = instr_mem_q[rd_ptr_q];
  assign bus.if_pc     = pc_mem_q[rd_ptr_q];
  assign bus.if_op     = bus.if_instr[15:14];

`ifdef IF_PERF_CNT_EN
  logic [15:0] fetch_cnt_q, fetch_cnt_d;
  logic [15:0] flush_cnt_q, flush_cnt_d;

  always_comb begin
    fetch_cnt_d = fetch_cnt_q;
    flush_cnt_d = flush_cnt_q;
    if (push && (fetch_cnt_q != 16'hFFFF)) begin
      fetch_cnt_d = fetch_cnt_q + 16'd1;
    end
    if (bus.branch_taken && (flush_cnt_q != 16'hFFFF)) begin
      flush_cnt_d = flush_cnt_q + 16'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      fetch_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      fetch_cnt_q <= fetch_cnt_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

  assign perf_fetch_cnt = fetch_cnt_q;
  assign perf_flush_cnt = flush_cnt_q;
`endif

endmodule

// File: tb/tb_fetch_stage.sv
// tb_fetch_stage
//   Directed bench for fetch_stage: sequential fetch, back-pressure, redirects
//   with and without a coincident ack, PC wrap (second instance with
//   RESET_PC=FFFC), and reset in the middle of a request.
module tb_fetch_stage;
  logic clk;
  logic rst;
  int   checks;
  int   failures;
  logic auto_ack;

  fetch_stage_if bus();
  fetch_stage_if bus_hi();

`ifdef IF_PERF_CNT_EN
  logic [15:0] perf_fetch_cnt, perf_flush_cnt;
  logic [15:0] perf_fetch_hi, perf_flush_hi;
`endif

  fetch_stage #(.RESET_PC(16'h0000), .BUF_DEPTH(2)) u_dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
`ifdef IF_PERF_CNT_EN
    ,
    .perf_fetch_cnt (perf_fetch_cnt),
    .perf_flush_cnt (perf_flush_cnt)
`endif
  );

  fetch_stage #(.RESET_PC(16'hFFFC), .BUF_DEPTH(2)) u_dut_hi (
    .clk (clk),
    .rst (rst),
    .bus (bus_hi)
`ifdef IF_PERF_CNT_EN
    ,
    .perf_fetch_cnt (perf_fetch_hi),
    .perf_flush_cnt (perf_flush_hi)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic drive_mem();
    bus.imem_ack   = bus.imem_req;
    bus.imem_rdata = 16'h4000 + bus.imem_addr;
  endtask

  // Advance one edge, then settle; the hi instance always acks every request.
  task automatic tick();
    @(posedge clk);
    #1;
    if (auto_ack) drive_mem();
    bus_hi.imem_ack   = bus_hi.imem_req;
    bus_hi.imem_rdata = 16'h4000 + bus_hi.imem_addr;
  endtask

  task automatic do_reset();
    rst                = 1'b1;
    auto_ack           = 1'b0;
    bus.branch_taken   = 1'b0;
    bus.branch_target  = 16'h0000;
    bus.imem_ack       = 1'b1;  // acks during reset must be ignored
    bus.imem_rdata     = 16'hBEEF;
    tick();
    tick();
    chk("rst_req", bus.imem_req, 1'b0);
    chk("rst_valid", bus.if_valid, 1'b0);
    chk("rst_addr", bus.imem_addr, 16'h0000);
    rst = 1'b0;             // ack stays high into the first post-reset cycle
  endtask

  logic [15:0] hi_addrs [4];
  logic [15:0] exp_pc;

  initial begin
    checks   = 0;
    failures = 0;
    hi_addrs[0] = 16'hFFFC; hi_addrs[1] = 16'hFFFE;
    hi_addrs[2] = 16'h0000; hi_addrs[3] = 16'h0002;
    bus.if_ready         = 1'b1;
    bus_hi.if_ready      = 1'b1;
    bus_hi.branch_taken  = 1'b0;
    bus_hi.branch_target = 16'h0000;
    bus_hi.imem_ack      = 1'b0;
    bus_hi.imem_rdata    = 16'h0000;

    // 1: sequential fetch at one instruction per cycle (+5: PC wrap)
    do_reset();
`ifdef IF_PERF_CNT_EN
    chk("perf_fetch_rst", perf_fetch_cnt, 16'd0);
    chk("perf_flush_rst", perf_flush_cnt, 16'd0);
`endif
    tick();
    chk("t1_req", bus.imem_req, 1'b1);
    chk("t1_addr0", bus.imem_addr, 16'h0000);
    chk("t1_noack_push", bus.if_valid, 1'b0);
    chk("t5_addr0", bus_hi.imem_addr, hi_addrs[0]);
    auto_ack = 1'b1;
    drive_mem();
    for (int i = 0; i < 6; i++) begin
      tick();
      chk("t1_valid", bus.if_valid, 1'b1);
      chk("t1_pc", bus.if_pc, 16'(2 * i));
      chk("t1_instr", bus.if_instr, 16'(16'h4000 + 2 * i));
      chk("t1_op", bus.if_op, 2'b01);
      chk("t1_addr", bus.imem_addr, 16'(2 * i + 2));
      if (i < 3) chk("t5_addr", bus_hi.imem_addr, hi_addrs[i + 1]);
    end

    // 2: back-pressure fills both entries and stops requesting
    bus.if_ready = 1'b0;
    do_reset();
    tick();
    auto_ack = 1'b1;
    drive_mem();
    tick();
    tick();
    chk("t2_req_drop", bus.imem_req, 1'b0);
    chk("t2_head_pc", bus.if_pc, 16'h0000);
    tick();
    tick();
    chk("t2_req_held", bus.imem_req, 1'b0);
    chk("t2_instr_held", bus.if_instr, 16'h4000);
    bus.if_ready = 1'b1;
    exp_pc = 16'h0000;
    for (int i = 0; i < 8; i++) begin
      if (bus.if_valid && bus.if_ready) begin
        chk("t2_seq_pc", bus.if_pc, exp_pc);
        exp_pc = exp_pc + 16'd2;
      end
      tick();
    end
    chk("t2_progress", exp_pc, 16'd16);

    // 3: redirect while waiting; the late ack is dropped
    do_reset();
    tick();
    auto_ack = 1'b1;
    drive_mem();
    tick();
    tick();
    tick();
    chk("t3_addr6", bus.imem_addr, 16'h0006);
    auto_ack          = 1'b0;
    bus.imem_ack      = 1'b0;
    bus.branch_taken  = 1'b1;
    bus.branch_target = 16'h0081;
    tick();
    bus.branch_taken = 1'b0;
    chk("t3_flush", bus.if_valid, 1'b0);
    chk("t3_req_hold", bus.imem_req, 1'b1);
    chk("t3_addr_hold", bus.imem_addr, 16'h0006);
    tick();
    tick();
    bus.imem_ack   = 1'b1;
    bus.imem_rdata = 16'hDEAD;
    tick();
    bus.imem_ack = 1'b0;
    chk("t3_req_off", bus.imem_req, 1'b0);
    chk("t3_dropped", bus.if_valid, 1'b0);
    tick();
    chk("t3_new_addr", bus.imem_addr, 16'h0080);
    auto_ack = 1'b1;
    drive_mem();
    tick();
    chk("t3_first_pc", bus.if_pc, 16'h0080);
    chk("t3_first_instr", bus.if_instr, 16'h4080);
    chk("t3_first_valid", bus.if_valid, 1'b1);

    // 4: redirect in the same cycle as an ack
    do_reset();
    tick();
    auto_ack = 1'b1;
    drive_mem();
    tick();
    chk("t4_valid_pre", bus.if_valid, 1'b1);
    auto_ack          = 1'b0;
    bus.imem_ack      = 1'b1;
    bus.imem_rdata    = 16'hBAD2;
    bus.branch_taken  = 1'b1;
    bus.branch_target = 16'h0100;
    tick();
    bus.branch_taken = 1'b0;
    bus.imem_ack     = 1'b0;
    chk("t4_valid_off", bus.if_valid, 1'b0);
    chk("t4_req_off", bus.imem_req, 1'b0);
    tick();
    chk("t4_new_addr", bus.imem_addr, 16'h0100);
    chk("t4_req_on", bus.imem_req, 1'b1);
    auto_ack = 1'b1;
    drive_mem();
    tick();
    chk("t4_first_pc", bus.if_pc, 16'h0100);
    chk("t4_first_instr", bus.if_instr, 16'h4100);

    // 6: reset in the middle of a request, ack the following cycle
    do_reset();
    bus.imem_ack = 1'b0;
    tick();
    chk("t6_req_pre", bus.imem_req, 1'b1);
    rst = 1'b1;
    tick();
    chk("t6_req_rst", bus.imem_req, 1'b0);
    chk("t6_valid_rst", bus.if_valid, 1'b0);
    chk("t6_addr_rst", bus.imem_addr, 16'h0000);
`ifdef IF_PERF_CNT_EN
    chk("t6_perf_fetch_rst", perf_fetch_cnt, 16'd0);
    chk("t6_perf_flush_rst", perf_flush_cnt, 16'd0);
`endif
    rst            = 1'b0;
    bus.imem_ack   = 1'b1;
    bus.imem_rdata = 16'hDEAD;
    tick();
    chk("t6_ack_ignored", bus.if_valid, 1'b0);
    chk("t6_restart_addr", bus.imem_addr, 16'h0000);
    chk("t6_restart_req", bus.imem_req, 1'b1);
    auto_ack = 1'b1;
    drive_mem();
    tick();
    chk("t6_first_pc", bus.if_pc, 16'h0000);
    chk("t6_first_instr", bus.if_instr, 16'h4000);
`ifdef IF_PERF_CNT_EN
    chk("t6_perf_fetch", perf_fetch_cnt, 16'd1);
    chk("t6_perf_flush", perf_flush_cnt, 16'd0);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
